// File: rtl/bus_arbiter_if.sv
// Serial system bus bundle between two masters, the arbiter and the slaves.
// arb is the arbiter's view; master and slave are the two endpoints.
interface bus_arbiter_if;
  logic [1:0] m_req;
  logic [1:0] m_grant;
  logic [1:0] m_mode;
  logic [1:0] m_wr;
  logic [1:0] m_valid;
  logic [1:0] m_ready;
  logic [1:0] m_rd;
  logic [1:0] m_sready;
  logic [1:0] m_svalid;
  logic       bus_mode;
  logic       bus_wr;
  logic       bus_master_valid;
  logic       bus_master_ready;
  logic       bus_rd;
  logic       bus_slave_ready;
  logic       bus_slave_valid;

  modport arb (
    input  m_req, m_mode, m_wr,
    input  m_valid, m_ready,
    input  bus_rd, bus_slave_ready,
    input  bus_slave_valid,
    output m_grant, m_rd,
    output m_sready, m_svalid,
    output bus_mode, bus_wr,
    output bus_master_valid,
    output bus_master_ready
  );

  modport master (
    output m_req, m_mode, m_wr,
    output m_valid, m_ready,
    input  m_grant, m_rd,
    input  m_sready, m_svalid
  );

  modport slave (
    input  bus_mode, bus_wr,
    input  bus_master_valid,
    input  bus_master_ready,
    output bus_rd, bus_slave_ready,
    output bus_slave_valid
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the serial system bus,
// with a slave-silence watchdog and a one-cycle gap between owners.
module bus_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rstn,
  bus_arbiter_if.arb   bif,
  output logic         timeout,
  output logic         timeout_id
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  state_t        state;
  logic [1:0]    grant;
  logic [1:0]    mask;
  logic          last_grant;
  logic [CW-1:0] cnt;

  logic       gid;
  logic       act;
  logic       expire;
  logic [1:0] elig;
  logic       win;

  assign gid    = grant[1];
  assign act    = bif.bus_slave_ready | bif.bus_slave_valid;
  assign expire = (state == BUSY) && (cnt == CNT_LAST) && !act;
  assign elig   = bif.m_req & ~mask;

  always_comb begin
    win = 1'b0;
    unique case (elig)
      2'b11:   win = ~last_grant;
      2'b10:   win = 1'b1;
      default: win = 1'b0;
    endcase
  end

  // Grant is one-hot-or-zero, so AND-OR gives a clean mux that idles at 0.
  assign bif.m_grant          = grant;
  assign bif.bus_mode         = |(grant & bif.m_mode);
  assign bif.bus_wr           = |(grant & bif.m_wr);
  assign bif.bus_master_valid = |(grant & bif.m_valid);
  assign bif.bus_master_ready = |(grant & bif.m_ready);
  assign bif.m_rd     = grant & {2{bif.bus_rd}};
  assign bif.m_sready = grant & {2{bif.bus_slave_ready}};
  assign bif.m_svalid = grant & {2{bif.bus_slave_valid}};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      grant      <= 2'b00;
      mask       <= 2'b00;
      last_grant <= 1'b1;
      cnt        <= '0;
      timeout    <= 1'b0;
      timeout_id <= 1'b0;
    end else begin
      timeout <= 1'b0;
      mask    <= mask & bif.m_req;
      unique case (state)
        IDLE: begin
          if (|elig) begin
            grant      <= win ? 2'b10 : 2'b01;
            last_grant <= win;
            cnt        <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          cnt <= act ? '0 : cnt + CW'(1);
          // A release wins over a coincident watchdog expiry.
          if (!bif.m_req[gid]) begin
            grant <= 2'b00;
            state <= GAP;
          end else if (expire) begin
            grant      <= 2'b00;
            state      <= GAP;
            timeout    <= 1'b1;
            timeout_id <= gid;
            mask[gid]  <= 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter against an
// owner/silence-count reference model.
module tb_bus_arbiter;

  localparam int TO     = 8;
  localparam int NCYC   = 4000;

  typedef struct packed {
    logic [1:0] grant;
    logic [3:0] bus;
    logic [5:0] ret;
    logic       to;
    logic       tid;
  } exp_t;

  logic clk;
  logic rstn;
  logic timeout;
  logic timeout_id;

  bus_arbiter_if bif ();

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bif        (bif),
    .timeout    (timeout),
    .timeout_id (timeout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   run      = 1'b0;

  // Reference model: who owns the bus, how long the slave has been
  // silent, and how many dead cycles remain before arbitration.
  int owner;
  int dead;
  int silent;
  int last;
  bit masked [2];
  bit pulse;
  bit tid;
  int n_to;
  int n_grants;

  task automatic model_reset();
    owner  = -1;
    dead   = 0;
    silent = 0;
    last   = 1;
    masked = '{1'b0, 1'b0};
    pulse  = 1'b0;
    tid    = 1'b0;
  endtask

  task automatic model_step();
    bit nm [2];
    bit e0;
    bit e1;
    bit act;
    if (!rstn) begin
      model_reset();
      return;
    end
    pulse = 1'b0;
    act   = bif.bus_slave_ready || bif.bus_slave_valid;
    for (int i = 0; i < 2; i++)
      nm[i] = masked[i] && bif.m_req[i];
    if (owner >= 0) begin
      silent = act ? 0 : silent + 1;
      if (!bif.m_req[owner]) begin
        owner = -1;
        dead  = 1;
      end else if (silent == TO) begin
        pulse     = 1'b1;
        tid       = owner[0];
        nm[owner] = 1'b1;
        owner     = -1;
        dead      = 1;
        n_to++;
      end
    end else if (dead > 0) begin
      dead--;
    end else begin
      e0 = bif.m_req[0] && !masked[0];
      e1 = bif.m_req[1] && !masked[1];
      if (e0 && e1) owner = 1 - last;
      else if (e0)  owner = 0;
      else if (e1)  owner = 1;
      if (owner >= 0) begin
        last   = owner;
        silent = 0;
        n_grants++;
      end
    end
    masked = nm;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e       = '0;
    e.to    = pulse;
    e.tid   = tid;
    if (owner >= 0) begin
      e.grant = 2'(1 << owner);
      e.bus   = {bif.m_mode[owner], bif.m_wr[owner],
                 bif.m_valid[owner], bif.m_ready[owner]};
      e.ret[owner]     = bif.bus_rd;
      e.ret[2 + owner] = bif.bus_slave_ready;
      e.ret[4 + owner] = bif.bus_slave_valid;
    end
    return e;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty @%0t: got 0 expected 1", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("grant", 8'(bif.m_grant), 8'(e.grant));
        check("bus_out", 8'({bif.bus_mode, bif.bus_wr,
              bif.bus_master_valid, bif.bus_master_ready}), 8'(e.bus));
        check("master_ret", 8'({bif.m_svalid, bif.m_sready,
              bif.m_rd}), 8'(e.ret));
        check("timeout", 8'(timeout), 8'(e.to));
        check("timeout_id", 8'(timeout_id), 8'(e.tid));
      end
    end
  end

  task automatic drive_random(int pct);
    rstn = ($urandom_range(0, 399) != 0);
    for (int i = 0; i < 2; i++)
      if ($urandom_range(0, 99) < 8) bif.m_req[i] = ~bif.m_req[i];
    bif.m_mode  = 2'($urandom);
    bif.m_wr    = 2'($urandom);
    bif.m_valid = 2'($urandom);
    bif.m_ready = 2'($urandom);
    bif.bus_rd          = 1'($urandom);
    bif.bus_slave_ready = ($urandom_range(0, 99) < pct);
    bif.bus_slave_valid = ($urandom_range(0, 99) < pct);
  endtask

  initial begin
    int pct;
    n_to     = 0;
    n_grants = 0;
    rstn     = 1'b0;
    bif.m_req   = 2'b00;
    bif.m_mode  = 2'b00;
    bif.m_wr    = 2'b00;
    bif.m_valid = 2'b00;
    bif.m_ready = 2'b00;
    bif.bus_rd          = 1'b0;
    bif.bus_slave_ready = 1'b0;
    bif.bus_slave_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    model_step();
    // Tie straight out of reset: master 0 must win first.
    #1;
    rstn      = 1'b1;
    bif.m_req = 2'b11;
    q.push_back(model_out());
    run = 1'b1;
    pct = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      model_step();
      #1;
      if (c % 50 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 0;
          1:       pct = 15;
          default: pct = 60;
        endcase
      end
      if (c < 3) rstn = 1'b1;
      else drive_random(pct);
      q.push_back(model_out());
    end
    @(negedge clk);
    #1;
    run = 1'b0;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: got %0d expected 0", q.size());
    end
    n_checks++;
    if (n_to == 0 || n_grants < 10) begin
      n_fail++;
      $display("FAIL coverage: got to=%0d grants=%0d expected >0 and >=10",
               n_to, n_grants);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
